// File: rtl/bsg_wormhole_dma_mem_responder.sv
// bsg_wormhole_dma_mem_responder: wormhole DMA endpoint turning cache read/write packets into word-addressed memory requests
module bsg_wormhole_dma_mem_responder #(
  parameter int flit_width_p = 32,
  parameter int cord_width_p = 4,
  parameter int len_width_p = 4,
  parameter int cid_width_p = 2,
  parameter int dma_addr_width_p = 32,
  parameter int burst_len_p = 4,
  parameter int mem_addr_width_p = 8,
  localparam int link_sif_width_lp = flit_width_p + 2
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic [cord_width_p-1:0] my_cord_i,
  input  logic [link_sif_width_lp-1:0] link_sif_i,
  output logic [link_sif_width_lp-1:0] link_sif_o,
  output logic mem_v_o,
  output logic mem_w_o,
  output logic [mem_addr_width_p-1:0] mem_addr_o,
  output logic [flit_width_p-1:0] mem_data_o,
  input  logic mem_ready_i,
  input  logic [flit_width_p-1:0] mem_data_i,
  input  logic mem_data_v_i,
  output logic mem_data_yumi_o
);
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RREQ, RWAIT} in_state_e;
  typedef enum logic [1:0] {OIDLE, OHDR, ODATA} out_state_e;
  localparam int cw = $clog2(burst_len_p + 1);
  localparam int off = $clog2(flit_width_p / 8);
  localparam int wnr_bit = cord_width_p + len_width_p + cid_width_p;
  localparam logic [cw-1:0] last = cw'(burst_len_p - 1);
  in_state_e st, st_n;
  out_state_e ost, ost_n;
  logic in_v, out_rdy, in_rdy, out_v, out_done, mem_fire, in_fire, live_r, wnr_r;
  logic [flit_width_p-1:0] in_data, out_data, hdr;
  logic [dma_addr_width_p-1:0] beat_addr;
  logic [cord_width_p-1:0] src_cord_r;
  logic [cid_width_p-1:0] src_cid_r;
  logic [mem_addr_width_p-1:0] addr_r;
  logic [cw-1:0] cnt_r, ocnt_r;
  assign {in_v, out_rdy, in_data} = link_sif_i;
  assign beat_addr = in_data[dma_addr_width_p-1:0] >> off;
  // live_r keeps ready low until the first edge after reset release
  assign in_rdy = live_r & ((st == IDLE) | (st == ADDR) | ((st == WDATA) & mem_ready_i));
  assign in_fire = in_v & in_rdy;
  assign mem_v_o = (st == WDATA) ? in_v : (st == RREQ);
  assign mem_w_o = st == WDATA;
  assign mem_addr_o = addr_r;
  assign mem_data_o = in_data;
  assign mem_fire = mem_v_o & mem_ready_i;
  assign hdr = flit_width_p'({cid_width_p'(0), my_cord_i, 1'b0, src_cid_r, len_width_p'(burst_len_p), src_cord_r});
  assign out_v = (ost == OHDR) | ((ost == ODATA) & mem_data_v_i);
  assign out_data = (ost == OHDR) ? hdr : (ost == ODATA) ? mem_data_i : '0;
  assign mem_data_yumi_o = (ost == ODATA) & mem_data_v_i & out_rdy;
  assign out_done = mem_data_yumi_o & (ocnt_r == last);
  assign link_sif_o = {out_v, in_rdy, out_data};
  always_comb begin
    st_n = st;
    ost_n = ost;
    unique case (st)
      IDLE: st_n = in_fire ? ADDR : IDLE;
      ADDR: st_n = in_fire ? (wnr_r ? WDATA : RREQ) : ADDR;
      WDATA: st_n = (mem_fire && cnt_r == last) ? IDLE : WDATA;
      RREQ: st_n = (mem_fire && cnt_r == last) ? (out_done ? IDLE : RWAIT) : RREQ;
      RWAIT: st_n = out_done ? IDLE : RWAIT;
      default: st_n = IDLE;
    endcase
    unique case (ost)
      OIDLE: ost_n = (st == ADDR && in_fire && !wnr_r) ? OHDR : OIDLE;
      OHDR: ost_n = out_rdy ? ODATA : OHDR;
      ODATA: ost_n = out_done ? OIDLE : ODATA;
      default: ost_n = OIDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      st <= IDLE;
      ost <= OIDLE;
      live_r <= 1'b0;
      wnr_r <= 1'b0;
      src_cord_r <= '0;
      src_cid_r <= '0;
      addr_r <= '0;
      cnt_r <= '0;
      ocnt_r <= '0;
    end else begin
      st <= st_n;
      ost <= ost_n;
      live_r <= 1'b1;
      if (st == IDLE && in_fire) begin
        wnr_r <= in_data[wnr_bit];
        src_cord_r <= in_data[wnr_bit+1 +: cord_width_p];
        src_cid_r <= in_data[wnr_bit+1+cord_width_p +: cid_width_p];
      end
      if (st == ADDR && in_fire) begin
        addr_r <= beat_addr[mem_addr_width_p-1:0];
        cnt_r <= '0;
      end else if (mem_fire) begin
        addr_r <= addr_r + mem_addr_width_p'(1);
        cnt_r <= cnt_r + cw'(1);
      end
      if (ost == OHDR) ocnt_r <= '0;
      else if (mem_data_yumi_o) ocnt_r <= ocnt_r + cw'(1);
    end
  end
endmodule

// File: tb/tb_bsg_wormhole_dma_mem_responder.sv
// tb_bsg_wormhole_dma_mem_responder: directed checks of read/write/stall/wrap/reset behaviour
module tb_bsg_wormhole_dma_mem_responder;
  localparam logic [31:0] RD_HDR = 32'h0000_A803;
  localparam logic [31:0] WR_HDR = 32'h0000_AC03;
  localparam logic [31:0] RP_HDR = 32'h0000_1945;
  logic clk_i = 1'b0;
  logic reset_n_i;
  logic v, rr, mr_base, tog_en;
  logic tog = 1'b0;
  logic [31:0] d;
  logic [33:0] lo;
  logic mem_v, mem_w, mem_ready, mem_data_v, yumi;
  logic [7:0] mem_addr;
  logic [31:0] mem_data_o, mem_data_i;
  logic v2;
  logic [31:0] d2;
  logic [33:0] lo2;
  logic mem2_v, mem2_w, yumi2;
  logic [3:0] mem2_addr;
  logic [31:0] mem2_data;
  logic [31:0] fq [8];
  logic [3:0] wp, rp;
  logic [7:0] wa [64], ra [64];
  logic [31:0] wd [64], od [64];
  int oc [64], ic [64];
  int cyc = 0, wn = 0, rn = 0, n_out = 0, n_in = 0;
  int nchk = 0, nfail = 0;
  always #5 clk_i = ~clk_i;
  assign mem_ready = tog_en ? tog : mr_base;
  always @(negedge clk_i) tog <= ~tog;
  bsg_wormhole_dma_mem_responder #(.mem_addr_width_p(8)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .my_cord_i(4'd3),
    .link_sif_i({v, rr, d}), .link_sif_o(lo),
    .mem_v_o(mem_v), .mem_w_o(mem_w), .mem_addr_o(mem_addr), .mem_data_o(mem_data_o),
    .mem_ready_i(mem_ready), .mem_data_i(mem_data_i), .mem_data_v_i(mem_data_v),
    .mem_data_yumi_o(yumi));
  bsg_wormhole_dma_mem_responder #(.mem_addr_width_p(4)) dut2 (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .my_cord_i(4'd3),
    .link_sif_i({v2, 1'b1, d2}), .link_sif_o(lo2),
    .mem_v_o(mem2_v), .mem_w_o(mem2_w), .mem_addr_o(mem2_addr), .mem_data_o(mem2_data),
    .mem_ready_i(1'b1), .mem_data_i(32'h0), .mem_data_v_i(1'b0),
    .mem_data_yumi_o(yumi2));
  // one-cycle memory: read data appears the cycle after the request, in order
  assign mem_data_v = wp != rp;
  assign mem_data_i = fq[rp[2:0]];
  always @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (mem_v && mem_ready && !mem_w) begin
        fq[wp[2:0]] <= 32'hA000_0000 | {24'h0, mem_addr};
        wp <= wp + 4'd1;
      end
      if (yumi) rp <= rp + 4'd1;
    end
  end
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (mem_v && mem_ready && mem_w) begin
      wa[wn] <= mem_addr;
      wd[wn] <= mem_data_o;
      wn <= wn + 1;
    end
    if (mem_v && mem_ready && !mem_w) begin
      ra[rn] <= mem_addr;
      rn <= rn + 1;
    end
    if (lo[33] && rr) begin
      od[n_out] <= lo[31:0];
      oc[n_out] <= cyc;
      n_out <= n_out + 1;
    end
    if (v && lo[32]) begin
      ic[n_in] <= cyc;
      n_in <= n_in + 1;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [31:0] f);
    int k = 0;
    v = 1'b1;
    d = f;
    #1;
    while (!lo[32] && k < 60) begin
      @(negedge clk_i);
      #1;
      k++;
    end
    if (k >= 60) chk("send_timeout", 32'(k), 32'd0);
    @(negedge clk_i);
    v = 1'b0;
  endtask
  task automatic wait_out(input int n);
    int k = 0;
    while (n_out < n && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    chk("out_count", 32'(n_out), 32'(n));
  endtask
  task automatic chk_read(input int ob, input int rb, input logic [7:0] base);
    chk("rep_hdr", od[ob], RP_HDR);
    for (int i = 0; i < 4; i++) begin
      chk("rd_addr", {24'h0, ra[rb+i]}, {24'h0, base + 8'(i)});
      chk("rep_data", od[ob+1+i], 32'hA000_0000 | {24'h0, base + 8'(i)});
    end
  endtask
  initial begin
    int ob, rb, wb, ib;
    logic [3:0] wexp [4];
    wexp = '{4'hE, 4'hF, 4'h0, 4'h1};
    reset_n_i = 1'b0;
    v = 1'b0; d = '0; rr = 1'b1; mr_base = 1'b1; tog_en = 1'b0;
    v2 = 1'b0; d2 = '0;
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_v", lo[33], 1'b0);
    chk("rst_rdy", lo[32], 1'b0);
    chk("rst_mem_v", mem_v, 1'b0);
    chk("rst_yumi", yumi, 1'b0);
    reset_n_i = 1'b1;
    #1;
    chk("rdy_before_edge", lo[32], 1'b0);
    @(negedge clk_i);
    #1;
    chk("rdy_after_edge", lo[32], 1'b1);
    // basic read of 0x100 -> beats 0x40..0x43
    ob = n_out; rb = rn;
    send(RD_HDR);
    send(32'h100);
    #1;
    chk("t2_hdr_v", lo[33], 1'b1);
    chk("t2_hdr", lo[31:0], RP_HDR);
    chk("t2_mem_v", mem_v, 1'b1);
    chk("t2_mem_addr", {24'h0, mem_addr}, 32'h40);
    wait_out(ob + 5);
    chk("rd_count", 32'(rn - rb), 32'd4);
    chk_read(ob, rb, 8'h40);
    // posted write with mem_ready toggling
    tog_en = 1'b1;
    ob = n_out; wb = wn;
    send(WR_HDR);
    send(32'h20);
    for (int i = 0; i < 4; i++) send(32'hDDDD_0000 + 32'(i));
    repeat (4) @(negedge clk_i);
    tog_en = 1'b0;
    chk("wr_count", 32'(wn - wb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("wr_addr", {24'h0, wa[wb+i]}, 32'h8 + 32'(i));
      chk("wr_data", wd[wb+i], 32'hDDDD_0000 + 32'(i));
    end
    chk("wr_no_reply", 32'(n_out), 32'(ob));
    // reply stalled by the router for 10 cycles
    rr = 1'b0;
    ob = n_out; rb = rn;
    send(RD_HDR);
    send(32'h200);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("stall_v", lo[33], 1'b1);
      chk("stall_hdr", lo[31:0], RP_HDR);
      chk("stall_yumi", yumi, 1'b0);
      @(negedge clk_i);
    end
    rr = 1'b1;
    wait_out(ob + 5);
    chk_read(ob, rb, 8'h80);
    // back-to-back read then write
    ob = n_out; rb = rn; wb = wn; ib = n_in;
    send(RD_HDR);
    send(32'h300);
    send(WR_HDR);
    chk("b2b_gap", 32'(ic[ib+2] - oc[ob+4]), 32'd1);
    send(32'h40);
    for (int i = 0; i < 4; i++) send(32'hBEEF_0000 + 32'(i));
    repeat (3) @(negedge clk_i);
    chk_read(ob, rb, 8'hC0);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_wr_addr", {24'h0, wa[wb+i]}, 32'h10 + 32'(i));
      chk("b2b_wr_data", wd[wb+i], 32'hBEEF_0000 + 32'(i));
    end
    // reset in the middle of a read reply
    ob = n_out;
    send(RD_HDR);
    send(32'h3F0);
    for (int k = 0; k < 100 && n_out < ob + 3; k++) @(negedge clk_i);
    reset_n_i = 1'b0;
    #1;
    chk("mid_rst_v", lo[33], 1'b0);
    chk("mid_rst_rdy", lo[32], 1'b0);
    chk("mid_rst_mem_v", mem_v, 1'b0);
    chk("mid_rst_yumi", yumi, 1'b0);
    chk("mid_rst_flits", 32'(n_out), 32'(ob + 3));
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    repeat (6) @(negedge clk_i);
    chk("no_partial_reply", 32'(n_out), 32'(ob + 3));
    ob = n_out; rb = rn;
    send(RD_HDR);
    send(32'h100);
    wait_out(ob + 5);
    chk_read(ob, rb, 8'h40);
    // 4-bit memory address wraps 0xE -> 0x1
    v2 = 1'b1;
    d2 = WR_HDR;
    @(negedge clk_i);
    d2 = 32'h38;
    @(negedge clk_i);
    for (int i = 0; i < 4; i++) begin
      d2 = 32'h5A5A_0000 + 32'(i);
      #1;
      chk("wrap_v", mem2_v, 1'b1);
      chk("wrap_w", mem2_w, 1'b1);
      chk("wrap_addr", {28'h0, mem2_addr}, {28'h0, wexp[i]});
      @(negedge clk_i);
    end
    v2 = 1'b0;
    #1;
    chk("wrap_done_mem_v", mem2_v, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/bsg_wormhole_dma_mem_responder.md
# bsg_wormhole_dma_mem_responder

Memory-side endpoint of the vcache DMA wormhole protocol. Sits on the P port of the off-array wormhole router at the far end of a vcache row. It accepts cache DMA packets, either a read request or a write with a data burst, and drives a word-addressed memory request interface. For reads it returns a header flit followed by the burst data to the requesting vcache. It handles one transaction at a time.

## Interface
- flit_width_p, none: wormhole flit width; equals the DMA data width, so one flit is one memory beat.
- cord_width_p, none: wormhole coordinate width.
- len_width_p, none: packet length field width.
- cid_width_p, none: concentrator id width.
- dma_addr_width_p, none: byte address width carried in the address flit.
- burst_len_p, none: beats per cache block; must be ≥1 and < 2^len_width_p.
- mem_addr_width_p, none: memory beat-address width.
- link_sif_width_lp, local: bsg_ready_and_link_sif_width(flit_width_p).
- clk_i, in, 1: clock.
- reset_n_i, in, 1: reset, asynchronous, active-low.
- my_cord_i, in, cord_width_p: this endpoint's wormhole coordinate.
- link_sif_i, in, link_sif_width_lp: {v, ready_and_rev, data} from the router P port.
- link_sif_o, out, link_sif_width_lp: {v, ready_and_rev, data} to the router P port.
- mem_v_o, out, 1: memory request valid.
- mem_w_o, out, 1: 1 = write, 0 = read.
- mem_addr_o, out, mem_addr_width_p: beat address.
- mem_data_o, out, flit_width_p: write data.
- mem_ready_i, in, 1: memory accepts the request when mem_v_o & mem_ready_i.
- mem_data_i, in, flit_width_p: read data; returned in request order.
- mem_data_v_i, in, 1: read data valid.
- mem_data_yumi_o, out, 1: read data consumed.

## Operation
- Header flit layout, LSB first: cord[cord_width_p], len[len_width_p], cid[cid_width_p], write_not_read[1], src_cord[cord_width_p], src_cid[cid_width_p]. Upper bits are zero.
- Address flit: byte address in bits [dma_addr_width_p-1:0].
- Base beat address = (addr >> log2(flit_width_p/8)), truncated to mem_addr_width_p. Each beat increments by 1 and wraps modulo 2^mem_addr_width_p.
- Input FSM states:
  - IDLE: accept header and latch write_not_read, src_cord, src_cid.
  - ADDR: accept address flit, latch base address, clear beat counters. Next state is WDATA if write, else RREQ.
  - WDATA: each accepted flit issues one write (mem_w_o=1, mem_data_o=flit). After the burst_len_p-th beat go to IDLE.
  - RREQ: issue burst_len_p reads (mem_w_o=0). After the last read is issued go to RWAIT.
  - RWAIT: stay until the output side has sent its final data flit, then go to IDLE.
- Writes are posted; no reply is sent. The incoming len field is not checked; the flit count is always burst_len_p (write data) or 0 (read).
- Output FSM, started on the ADDR→RREQ transition:
  - OHDR: send reply header with cord=src_cord, len=burst_len_p, cid=src_cid, write_not_read=0, src_cord=my_cord_i, src_cid=0.
  - ODATA: forward mem_data_i as link data with v=mem_data_v_i. mem_data_yumi_o = mem_data_v_i & link ready_and_rev. Return to OIDLE after burst_len_p data flits.
- Input ready (link_sif_o.ready_and_rev):
  - 1 in IDLE and ADDR.
  - mem_ready_i in WDATA (combinational path).
  - 0 in RREQ and RWAIT.
- mem_v_o:
  - In WDATA it equals link_sif_i.v.
  - In RREQ it is 1 while reads remain.
  - 0 in all other states.
- Beat counters are clog2(burst_len_p+1) bits wide.

## Timing
- Reset (reset_n_i=0, asynchronous): both FSMs go idle and counters clear. link_sif_o.v=0, ready_and_rev=0, mem_v_o=0, mem_data_yumi_o=0.
  - Reset mid-transaction abandons it; no partial reply is sent afterwards.
  - ready_and_rev goes to 1 on the first clk_i edge after deassertion.
- Read: header accepted at cycle T, address at T+1. Reply header v=1 and first mem read at T+2. Reply data follows memory latency, one flit per cycle when unstalled.
- The reply header is held until accepted. mem_data_yumi_o is never asserted before the header is accepted.
- Write: address at T+1; a data beat can write every cycle from T+2. Stalls follow mem_ready_i and link v.
- A new header is accepted no earlier than the cycle after the last read data flit, or the last write beat, is accepted.
- Write beat and link handshake occur in the same cycle; no flit is dropped or duplicated.

## Test plan
- Read, burst_len_p=4, flit_width_p=32, addr 0x100 from src_cord 5 / cid 1, with 1-cycle memory:
  - mem reads at beat addresses 0x40–0x43.
  - Reply header cord=5, len=4, cid=1, then 4 data flits in order.
- Write, addr 0x20, 4 beats D0..D3 with mem_ready_i toggling every cycle: exactly 4 writes at 0x8–0xB carrying D0..D3, no reply flit.
- Read with link ready_and_rev held 0 for 10 cycles after header valid:
  - Header stays stable.
  - mem_data_yumi_o=0 throughout the stall.
  - Data is not lost.
- Address wrap with mem_addr_width_p=4, base beat 0xE, burst 4: addresses 0xE, 0xF, 0x0, 0x1.
- Back-to-back read then write: the write header is accepted the cycle after the last read data flit is accepted; memory ordering is preserved.
- Assert reset_n_i mid-read after 2 data flits:
  - Outputs go to 0 immediately.
  - After release, a fresh read completes correctly.
